// File: rtl/wb_arbiter.sv
// Write-back arbiter for the register-bank write port: grants one of eight result
// sources per cycle. Define WB_ROUND_ROBIN_EN for round-robin priority (default: fixed, lowest index wins).
module wb_arbiter #(
    parameter int NUM_SRC    = 8,
    parameter int REG_ADDR_W = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SRC-1:0]            req,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] rd_in,
    input  logic                          stall,
    output logic [NUM_SRC-1:0]            ack,
    output logic [2:0]                    mux_sel,
    output logic                          reg_write,
    output logic [REG_ADDR_W-1:0]         write_reg,
    output logic                          busy
);

    typedef enum logic {
        IDLE,
        WRITE
    } state_e;

    state_e                  state_q, state_d;
    logic [2:0]              sel_q, sel_d;
    logic [REG_ADDR_W-1:0]   wreg_q, wreg_d;
    logic [NUM_SRC-1:0]      eff;
    logic [2:0]              start;
    logic [2:0]              win;
    logic                    found;

`ifdef WB_ROUND_ROBIN_EN
    logic [2:0]              ptr_q, ptr_d;
    assign start = ptr_q;
`else
    assign start = 3'd0;
`endif

    // Outputs decode straight from state, so an asynchronous reset kills the write at once.
    assign ack       = (state_q == WRITE) ? (NUM_SRC'(1) << sel_q) : '0;
    assign reg_write = (state_q == WRITE) && (wreg_q != '0);
    assign mux_sel   = sel_q;
    assign write_reg = wreg_q;

    // Masking the bit being acked stops a source that has not yet dropped req from winning twice.
    assign eff  = req & ~ack;
    assign busy = |eff;

    always_comb begin
        found = 1'b0;
        win   = 3'd0;
        for (int k = 0; k < NUM_SRC; k++) begin
            logic [2:0] idx;
            idx = start + 3'(k);
            if (!found && eff[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = IDLE;
        sel_d   = sel_q;
        wreg_d  = wreg_q;
`ifdef WB_ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif
        if (!stall && found) begin
            state_d = WRITE;
            sel_d   = win;
            wreg_d  = rd_in[int'(win)*REG_ADDR_W +: REG_ADDR_W];
`ifdef WB_ROUND_ROBIN_EN
            ptr_d   = win + 3'd1;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sel_q   <= 3'd0;
            wreg_q  <= '0;
`ifdef WB_ROUND_ROBIN_EN
            ptr_q   <= 3'd0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            wreg_q  <= wreg_d;
`ifdef WB_ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter; expected values are hand-derived
// for both the fixed-priority and WB_ROUND_ROBIN_EN builds.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  req = '0;
    logic [39:0] rd_in = '0;
    logic        stall = 1'b0;
    logic [7:0]  ack;
    logic [2:0]  mux_sel;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic        busy;

    int checks = 0;
    int errors = 0;

    wb_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .rd_in     (rd_in),
        .stall     (stall),
        .ack       (ack),
        .mux_sel   (mux_sel),
        .reg_write (reg_write),
        .write_reg (write_reg),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int i, input logic [4:0] v);
        rd_in[i*5 +: 5] = v;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        req   = '0;
        stall = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req   = 8'hFF;
        rd_in = '0;
        set_rd(0, 5'd5);
        set_rd(1, 5'd6);
        tick();
        tick();
        checks++;
        if ({ack, mux_sel, reg_write, write_reg} !== {8'h00, 3'd0, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL reset_values: got ack=%h sel=%0d we=%b wr=%0d, want ack=00 sel=0 we=0 wr=0",
                     ack, mux_sel, reg_write, write_reg);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({ack, mux_sel, reg_write, write_reg} !== {8'h01, 3'd0, 1'b1, 5'd5}) begin
            errors++;
            $display("FAIL reset_first_grant: got ack=%h sel=%0d we=%b wr=%0d, want ack=01 sel=0 we=1 wr=5",
                     ack, mux_sel, reg_write, write_reg);
        end
        req = '0;
        tick();
        checks++;
        if ({ack, reg_write, busy} !== {8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_then_idle: got ack=%h we=%b busy=%b, want ack=00 we=0 busy=0",
                     ack, reg_write, busy);
        end
    endtask

    task automatic test_single();
        apply_reset();
        rd_in = '0;
        set_rd(1, 5'd9);
        req = 8'h02;
        tick();
        checks++;
        if ({ack, mux_sel, reg_write, write_reg, busy} !== {8'h02, 3'd1, 1'b1, 5'd9, 1'b0}) begin
            errors++;
            $display("FAIL single_grant: got ack=%h sel=%0d we=%b wr=%0d busy=%b, want ack=02 sel=1 we=1 wr=9 busy=0",
                     ack, mux_sel, reg_write, write_reg, busy);
        end
        req = '0;
        tick();
        checks++;
        if ({ack, mux_sel, reg_write, write_reg, busy} !== {8'h00, 3'd1, 1'b0, 5'd9, 1'b0}) begin
            errors++;
            $display("FAIL single_idle_hold: got ack=%h sel=%0d we=%b wr=%0d busy=%b, want ack=00 sel=1 we=0 wr=9 busy=0",
                     ack, mux_sel, reg_write, write_reg, busy);
        end
    endtask

    task automatic test_contention();
        logic [2:0] exp_sel [5];
        logic [4:0] exp_wr  [5];
        apply_reset();
        rd_in = '0;
        set_rd(0, 5'd3);
        set_rd(7, 5'd4);
        req = 8'h81;
        tick();
        checks++;
        if ({ack, mux_sel, reg_write, write_reg, busy} !== {8'h01, 3'd0, 1'b1, 5'd3, 1'b1}) begin
            errors++;
            $display("FAIL contention_first: got ack=%h sel=%0d we=%b wr=%0d busy=%b, want ack=01 sel=0 we=1 wr=3 busy=1",
                     ack, mux_sel, reg_write, write_reg, busy);
        end
        req = 8'h80;
        tick();
        checks++;
        if ({ack, mux_sel, reg_write, write_reg, busy} !== {8'h80, 3'd7, 1'b1, 5'd4, 1'b0}) begin
            errors++;
            $display("FAIL contention_second: got ack=%h sel=%0d we=%b wr=%0d busy=%b, want ack=80 sel=7 we=1 wr=4 busy=0",
                     ack, mux_sel, reg_write, write_reg, busy);
        end
        req = '0;
        tick();

        // Held requests: the acked bit is masked, so two held sources alternate in either build.
        req = 8'h81;
        for (int i = 0; i < 4; i++) begin
            logic [2:0] s;
            s = (i % 2 == 0) ? 3'd0 : 3'd7;
            tick();
            checks++;
            if ({ack, mux_sel} !== {8'(1) << s, s}) begin
                errors++;
                $display("FAIL held_81_step%0d: got ack=%h sel=%0d, want sel=%0d", i, ack, mux_sel, s);
            end
        end
        req = '0;
        tick();

        // Three held sources separate the two priority schemes.
        apply_reset();
        set_rd(1, 5'd1);
        set_rd(2, 5'd2);
`ifdef WB_ROUND_ROBIN_EN
        exp_sel = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1};
        exp_wr  = '{5'd3, 5'd1, 5'd2, 5'd3, 5'd1};
`else
        exp_sel = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd0};
        exp_wr  = '{5'd3, 5'd1, 5'd3, 5'd1, 5'd3};
`endif
        req = 8'h07;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({ack, mux_sel, write_reg, reg_write} !== {8'(1) << exp_sel[i], exp_sel[i], exp_wr[i], 1'b1}) begin
                errors++;
                $display("FAIL held_07_step%0d: got ack=%h sel=%0d wr=%0d we=%b, want sel=%0d wr=%0d we=1",
                         i, ack, mux_sel, write_reg, reg_write, exp_sel[i], exp_wr[i]);
            end
        end
        req = '0;
        tick();
        checks++;
        if ({ack, reg_write, busy} !== {8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL contention_idle: got ack=%h we=%b busy=%b, want ack=00 we=0 busy=0",
                     ack, reg_write, busy);
        end
    endtask

    task automatic test_zero_dest();
        rd_in = '0;
        set_rd(0, 5'd0);
        req = 8'h01;
        tick();
        checks++;
        if ({ack, mux_sel, reg_write, write_reg} !== {8'h01, 3'd0, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL zero_dest: got ack=%h sel=%0d we=%b wr=%0d, want ack=01 sel=0 we=0 wr=0",
                     ack, mux_sel, reg_write, write_reg);
        end
        req = '0;
        tick();
    endtask

    task automatic test_stall();
        rd_in = '0;
        set_rd(4, 5'd7);
        stall = 1'b1;
        req   = 8'h10;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({ack, reg_write, busy} !== {8'h00, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL stall_cycle%0d: got ack=%h we=%b busy=%b, want ack=00 we=0 busy=1",
                         i, ack, reg_write, busy);
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if ({ack, mux_sel, reg_write, write_reg} !== {8'h10, 3'd4, 1'b1, 5'd7}) begin
            errors++;
            $display("FAIL stall_release: got ack=%h sel=%0d we=%b wr=%0d, want ack=10 sel=4 we=1 wr=7",
                     ack, mux_sel, reg_write, write_reg);
        end
        req = '0;
        tick();
    endtask

    task automatic test_reset_mid_write();
        rd_in = '0;
        set_rd(2, 5'd6);
        req = 8'h04;
        tick();
        checks++;
        if ({ack, reg_write} !== {8'h04, 1'b1}) begin
            errors++;
            $display("FAIL midwrite_grant: got ack=%h we=%b, want ack=04 we=1", ack, reg_write);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({ack, mux_sel, reg_write, write_reg} !== {8'h00, 3'd0, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL midwrite_async_abort: got ack=%h sel=%0d we=%b wr=%0d, want ack=00 sel=0 we=0 wr=0",
                     ack, mux_sel, reg_write, write_reg);
        end
        #1;
        reset = 1'b1;
        tick();
        checks++;
        if ({ack, mux_sel, reg_write, write_reg} !== {8'h04, 3'd2, 1'b1, 5'd6}) begin
            errors++;
            $display("FAIL midwrite_regrant: got ack=%h sel=%0d we=%b wr=%0d, want ack=04 sel=2 we=1 wr=6",
                     ack, mux_sel, reg_write, write_reg);
        end
        req = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_zero_dest();
        test_stall();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
